pulse_analyzer: RTL
===================

// Module: pulse_analyzer
// PURPOSE
//  Measures the timing of a digital pulse train on din, in aclk cycles.
//  Records three times: rise offset, fall time and period.
//  Emits each record as one 96-bit AXI-Stream beat whose field layout matches the pulse-generator cfg word,
//  so a captured record can be compared against, or fed back as, a generator configuration.
//  Sits between a GPIO/trigger input and an AXI-Stream FIFO or DMA.
// PARAMETERS
//  CONTINUOUS   "FALSE"  "TRUE": re-measure back-to-back periods; "FALSE": one record per enable assertion.
//  SYNC_STAGES  2        Synchronizer flops on din; legal range 2..4.
// PORTS
//  aclk            in   1   clock
//  aresetn         in   1   reset; synchronous, active-low
//  enable          in   1   level; arms measurement, deassert aborts/re-arms
//  din             in   1   asynchronous pulse input
//  m_axis_tdata    out  96  [31:0] t_rise, [63:32] t_fall, [95:64] t_period
//  m_axis_tvalid   out  1   record valid
//  m_axis_tready   in   1   downstream ready
//  busy            out  1   FSM in a WAIT_* state
//  overrun         out  1   sticky: a completed record was dropped
// BEHAVIOUR
//  Reset: tdata=0, tvalid=0, busy=0, overrun=0, FSM=IDLE, counter=0, sync flops=0.
//  Edge detection:
//   - din passes through SYNC_STAGES flops plus one previous-value register.
//   - An edge is seen L=SYNC_STAGES+1 cycles after din changes.
//   - The previous-value register updates in all states, so din already high at arm is NOT a rise.
//  Counter (32 bit):
//   - Held at 0 in IDLE.
//   - Increments once per cycle in WAIT_* states.
//   - Saturates at 32'hFFFFFFFF and never wraps.
//  FSM:
//   - IDLE -> WAIT_RISE when enable=1. The counter reads 0 in the first WAIT_RISE cycle.
//   - WAIT_RISE: on a rise, t_rise=counter -> WAIT_FALL.
//   - WAIT_FALL: on a fall, t_fall=counter -> WAIT_NEXT.
//   - WAIT_NEXT: on a rise, t_period=counter and the record completes.
//     - CONTINUOUS="FALSE": -> DONE.
//     - CONTINUOUS="TRUE": counter loads 0, the next t_rise=0 -> WAIT_FALL in the same cycle. No edge is lost.
//   - DONE: idle until enable=0, then -> IDLE.
//   - enable=0 in any state -> IDLE next cycle; any partial record is discarded.
//  Output register (one deep, independent of the FSM):
//   - A completed record loads tdata and sets tvalid=1 on the following cycle when tvalid=0 or (tvalid & tready).
//   - Otherwise the record is dropped and overrun=1.
//   - tdata is stable while tvalid & ~tready; tvalid clears on handshake unless reloaded in the same cycle.
//   - A pending record survives enable=0.
//   - overrun clears only on reset or while enable=0.
//  Captured fields are absolute counter values: t_fall-t_rise = high time; t_period-t_rise = period.
// CONFIGURATION
//  Macro PULSE_ANALYZER_TIMEOUT_EN.
//  Defined:
//   - Adds port cfg_timeout (in, 32).
//   - In any WAIT_* state with cfg_timeout!=0 and counter==cfg_timeout, the record completes early.
//   - Fields not yet captured read 32'hFFFFFFFF.
//   - Afterwards the FSM goes to DONE (single-shot) or to WAIT_RISE with counter=0 (continuous).
//  Undefined: no port; WAIT_* states wait indefinitely.
// STRUCTURE
//  Package pulse_analyzer_pkg:
//   - state enum {IDLE, WAIT_RISE, WAIT_FALL, WAIT_NEXT, DONE}
//   - FIELD_W=32
//   - SAT=32'hFFFFFFFF
//   - field offsets RISE_LSB=0, FALL_LSB=32, PERIOD_LSB=64
//  Sub-module pulse_analyzer_sync: SYNC_STAGES synchronizer plus rise/fall strobes.
// TESTING
//  1. Single shot, tready=1, L=3. din rises 7 cycles after arm, high 5, low 15
//     -> one beat {30,15,10}; no further beats while enable=1.
//  2. CONTINUOUS="TRUE", period 20, high 5
//     -> first beat as in 1; then beats {20,5,0} every 20 cycles; overrun=0.
//  3. Same as 2 with tready=0 for 50 cycles
//     -> the first beat is held stable, the next records are dropped, overrun=1;
//        overrun clears after enable=0.
//  4. din held high at arm, falls at cycle 4, rises at 10 -> t_rise is captured on the cycle-10 rise, not at arm.
//  5. enable dropped in WAIT_FALL -> no beat, busy=0 next cycle; re-arm restarts the counter at 0.
//  6. Timeout macro, cfg_timeout=100, din static low -> one beat with all three fields 32'hFFFFFFFF.
//     Also: aresetn=0 mid-beat -> tvalid=0.

Source files
------------

// File: rtl/pulse_analyzer_pkg.sv
// pulse_analyzer_pkg: shared types, field layout and helpers for the pulse analyzer.
// The record layout matches the pulse-generator cfg word: rise / fall / period, 32 bits each.
package pulse_analyzer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        WAIT_FALL,
        WAIT_NEXT,
        DONE
    } state_t;

    localparam int FIELD_W = 32;
    localparam int REC_W   = 3 * FIELD_W;

    localparam logic [FIELD_W-1:0] SAT = 32'hFFFF_FFFF;

    localparam int RISE_LSB   = 0;
    localparam int FALL_LSB   = 32;
    localparam int PERIOD_LSB = 64;

    // True for the three measuring states.
    function automatic logic is_wait(input state_t s);
        return (s == WAIT_RISE) || (s == WAIT_FALL) || (s == WAIT_NEXT);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FIELD_W-1:0] sat_inc(input logic [FIELD_W-1:0] v);
        return (v == SAT) ? v : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/pulse_analyzer_sync.sv
// pulse_analyzer_sync: metastability synchronizer for din plus registered rise/fall strobes.
// A change on din shows up as a one-cycle strobe SYNC_STAGES+1 cycles later.
// The previous-value register tracks din continuously, so a level that is
// already high when measurement starts never produces a rise strobe.
// SYNC_STAGES is expected to be in the range 2..4.
module pulse_analyzer_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // Synchronizer chain, previous-value register and edge strobes
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q <= '0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/pulse_analyzer.sv
// pulse_analyzer: measures rise offset, fall time and period of a pulse train on din
// in aclk cycles and emits each completed record as one 96-bit AXI-Stream beat.
// Optional feature: define PULSE_ANALYZER_TIMEOUT_EN to add cfg_timeout, which
// completes a record early (uncaptured fields all-ones) when the counter reaches it.
module pulse_analyzer
    import pulse_analyzer_pkg::*;
#(
    parameter string CONTINUOUS  = "FALSE",
    parameter int    SYNC_STAGES = 2
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic               din,
`ifdef PULSE_ANALYZER_TIMEOUT_EN
    input  logic [FIELD_W-1:0] cfg_timeout,
`endif
    output logic [REC_W-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               busy,
    output logic               overrun
);

    localparam bit CONT = (CONTINUOUS == "TRUE");

    state_t             state;
    state_t             state_next;
    logic [FIELD_W-1:0] counter;
    logic [FIELD_W-1:0] t_rise_q;
    logic [FIELD_W-1:0] t_fall_q;
    logic               rise;
    logic               fall;
    logic               timeout_hit;
    logic               cap_rise;
    logic               cap_fall;
    logic               complete;
    logic [FIELD_W-1:0] rec_rise;
    logic [FIELD_W-1:0] rec_fall;
    logic [FIELD_W-1:0] rec_period;
    logic [REC_W-1:0]   record;

    pulse_analyzer_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (din),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef PULSE_ANALYZER_TIMEOUT_EN
    assign timeout_hit = is_wait(state) && (cfg_timeout != '0) && (counter == cfg_timeout);
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture events; dropping enable abandons any partial record
    always_comb begin
        state_next = state;
        cap_rise   = 1'b0;
        cap_fall   = 1'b0;
        complete   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = WAIT_RISE;
                end
                WAIT_RISE, WAIT_FALL, WAIT_NEXT: begin
                    if (timeout_hit) begin
                        complete   = 1'b1;
                        state_next = CONT ? WAIT_RISE : DONE;
                    end else if (state == WAIT_RISE && rise) begin
                        cap_rise   = 1'b1;
                        state_next = WAIT_FALL;
                    end else if (state == WAIT_FALL && fall) begin
                        cap_fall   = 1'b1;
                        state_next = WAIT_NEXT;
                    end else if (state == WAIT_NEXT && rise) begin
                        complete = 1'b1;
                        if (CONT) begin
                            // The closing rise is also the opening rise of the next record.
                            cap_rise   = 1'b1;
                            state_next = WAIT_FALL;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Status and record assembly from the current state
    always_comb begin
        busy       = is_wait(state);
        rec_rise   = (state == WAIT_RISE) ? SAT : t_rise_q;
        rec_fall   = (state == WAIT_NEXT) ? t_fall_q : SAT;
        rec_period = timeout_hit ? SAT : counter;
        record     = '0;
        record[RISE_LSB   +: FIELD_W] = rec_rise;
        record[FALL_LSB   +: FIELD_W] = rec_fall;
        record[PERIOD_LSB +: FIELD_W] = rec_period;
    end

    // Cycle counter: zero outside WAIT_*, saturating count inside, re-based on restart
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            counter <= '0;
        end else if (!is_wait(state) || !is_wait(state_next)) begin
            counter <= '0;
        end else if (complete && cap_rise) begin
            // The restarting rise cycle is time 0, so the following cycle reads 1.
            counter <= FIELD_W'(1);
        end else if (complete) begin
            counter <= '0;
        end else begin
            counter <= sat_inc(counter);
        end
    end

    // Captured edge times; only read after being written in the same measurement
    always_ff @(posedge aclk) begin
        if (cap_rise) begin
            t_rise_q <= complete ? '0 : counter;
        end
        if (cap_fall) begin
            t_fall_q <= counter;
        end
    end

    // One-deep output register with sticky overrun on a dropped record
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (complete && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= record;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (!enable) begin
                overrun <= 1'b0;
            end else if (complete && m_axis_tvalid && !m_axis_tready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
